// File: rtl/gcd_host.sv
// Request-queueing host for an external iterative GCD core: buffers operand
// pairs, short-circuits zero operands, sequences the core and returns results.
module gcd_host #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 70000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             gcd_clr,
  output logic             gcd_start,
  output logic [WIDTH-1:0] gcd_data,
  input  logic             gcd_done,
  input  logic [WIDTH-1:0] gcd_result
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_A = 3'd2,
    LOAD_B = 3'd3,
    WAIT   = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic               in_ready_q, in_ready_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   gcd_q, gcd_d;
  logic               err_q, err_d;
  logic               valid_q, valid_d;
  logic               clr_q, clr_d;
  logic               start_q, start_d;
  logic [WIDTH-1:0]   data_q, data_d;

  logic               push_s, pop_s;
  logic [WIDTH-1:0]   head_a_s, head_b_s;

  assign push_s   = in_valid && in_ready_q;
  assign pop_s    = (state_q == IDLE) && (count_q != '0);
  assign head_a_s = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
  assign head_b_s = mem_q[rd_ptr_q][WIDTH-1:0];

  assign in_ready  = in_ready_q;
  assign out_valid = valid_q;
  assign out_gcd   = gcd_q;
  assign out_err   = err_q;
  assign gcd_clr   = clr_q;
  assign gcd_start = start_q;
  assign gcd_data  = data_q;

  // FIFO storage; contents are don't-care while empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_a, in_b};
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{AW{1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{AW{1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
    in_ready_d = (count_d != CNT_FULL);
  end

  // Sequencer; all visible outputs are derived from the next state and registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    gcd_d   = gcd_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (pop_s) begin
          a_d = head_a_s;
          b_d = head_b_s;
          if ((head_a_s == '0) && (head_b_s == '0)) begin
            gcd_d   = '0;
            err_d   = 1'b1;
            state_d = RESP;
          end else if (head_a_s == '0) begin
            gcd_d   = head_b_s;
            err_d   = 1'b0;
            state_d = RESP;
          end else if (head_b_s == '0) begin
            gcd_d   = head_a_s;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = CLEAR;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR:  state_d = LOAD_A;
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the timeout cycle still counts as a valid result.
        if (gcd_done) begin
          gcd_d   = gcd_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          gcd_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RESP);
    clr_d   = (state_d == CLEAR);
    start_d = (state_d == LOAD_A);
    if (state_d == LOAD_A) begin
      data_d = a_d;
    end else if (state_d == LOAD_B) begin
      data_d = b_d;
    end else begin
      data_d = '0;
    end
  end

  // State, pointer and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      gcd_q      <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      clr_q      <= 1'b0;
      start_q    <= 1'b0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      gcd_q      <= gcd_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      clr_q      <= clr_d;
      start_q    <= start_d;
      data_q     <= data_d;
    end
  end

endmodule

// File: tb/tb_gcd_host.sv
// Scoreboard bench for gcd_host with a behavioural GCD core model.
module tb_gcd_host;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_gcd;
  logic         out_err;
  logic         gcd_clr, gcd_start;
  logic [W-1:0] gcd_data;
  logic         gcd_done;
  logic [W-1:0] gcd_result;

  logic         done_model = 1'b0;
  logic         done_spur  = 1'b0;
  logic [W-1:0] res_model  = '0;

  assign gcd_done   = done_model | done_spur;
  assign gcd_result = done_spur ? 16'hDEAD : res_model;

  gcd_host #(.WIDTH(W), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_gcd(out_gcd), .out_err(out_err),
    .gcd_clr(gcd_clr), .gcd_start(gcd_start), .gcd_data(gcd_data),
    .gcd_done(gcd_done), .gcd_result(gcd_result)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] g;
    logic         e;
  } exp_t;

  exp_t   sb[$];
  int     checks_n = 0;
  int     fail_n   = 0;
  int     start_cnt = 0;
  logic [W-1:0] last_a = '0, last_b = '0;
  bit     core_en = 1'b1;
  int     core_delay = 5;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit timeout_exp);
    exp_t e;
    int   n;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("push_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (timeout_exp || (a == '0 && b == '0)) begin
      e.g = '0;
      e.e = 1'b1;
    end else begin
      e.g = gcd_ref(a, b);
      e.e = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_start(output bit seen);
    int n;
    n = 0;
    while (gcd_start !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    seen = (gcd_start === 1'b1);
    check("start_seen", {31'd0, seen}, 32'd1);
  endtask

  // Response monitor: pops the scoreboard on each handshake and checks stall stability.
  initial begin
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_gcd = '0;
    logic         prev_err = 1'b0;
    exp_t         e;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", {31'd0, out_valid}, 32'd1);
          check("stall_gcd", {16'd0, out_gcd}, {16'd0, prev_gcd});
          check("stall_err", {31'd0, out_err}, {31'd0, prev_err});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check("resp_gcd", {16'd0, out_gcd}, {16'd0, e.g});
            check("resp_err", {31'd0, out_err}, {31'd0, e.e});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_gcd   = out_gcd;
        prev_err   = out_err;
      end
    end
  end

  // Core model: checks the clear/start/load sequence and answers after core_delay cycles.
  initial begin
    logic prev_clr = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_clr = 1'b0;
      end else if (gcd_start) begin
        check("clr_before_start", {31'd0, prev_clr}, 32'd1);
        check("clr_one_cycle", {31'd0, gcd_clr}, 32'd0);
        start_cnt++;
        last_a = gcd_data;
        @(negedge clk);
        #1;
        check("load_b_start_low", {31'd0, gcd_start}, 32'd0);
        last_b = gcd_data;
        @(negedge clk);
        #1;
        check("wait_data_zero", {16'd0, gcd_data}, 32'd0);
        if (core_en) begin
          repeat (core_delay - 1) @(negedge clk);
          res_model  = gcd_ref(last_a, last_b);
          done_model = 1'b1;
          @(negedge clk);
          done_model = 1'b0;
        end
        prev_clr = 1'b0;
      end else begin
        prev_clr = gcd_clr;
      end
    end
  end

  initial begin
    bit seen;
    int n, s0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_gcd", {16'd0, out_gcd}, 32'd0);
    check("rst_gcd_start", {31'd0, gcd_start}, 32'd0);
    check("rst_gcd_clr", {31'd0, gcd_clr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Basic core transaction.
    push(16'd48, 16'd18, 1'b0);
    drain();
    check("core_a", {16'd0, last_a}, 32'd48);
    check("core_b", {16'd0, last_b}, 32'd18);
    check("start_count", start_cnt, 32'd1);

    // Zero-operand shortcuts never start the core.
    s0 = start_cnt;
    push(16'd0, 16'd35, 1'b0);
    push(16'd0, 16'd0, 1'b0);
    push(16'd44, 16'd0, 1'b0);
    drain();
    check("zero_no_start", start_cnt, s0);

    // Timeout with a silent core.
    core_en = 1'b0;
    push(16'd7, 16'd5, 1'b1);
    wait_start(seen);
    n = 0;
    while (seen && out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_latency", n - 2, 32'd20);
    drain();
    core_en = 1'b1;

    // Backpressure: 4 queued plus one in flight.
    out_ready = 1'b0;
    push(16'd12, 16'd8, 1'b0);
    push(16'd0, 16'd9, 1'b0);
    push(16'd21, 16'd14, 1'b0);
    push(16'd0, 16'd0, 1'b0);
    check("in_ready_not_full", {31'd0, in_ready}, 32'd1);
    push(16'd17, 16'd5, 1'b0);
    check("in_ready_full", {31'd0, in_ready}, 32'd0);
    repeat (12) @(negedge clk);
    check("in_ready_full_hold", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    drain();

    // Reset while waiting on the core.
    core_en = 1'b0;
    push(16'd100, 16'd75, 1'b0);
    wait_start(seen);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_gcd_data", {16'd0, gcd_data}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_gcd_start", {31'd0, gcd_start}, 32'd0);
    check("mid_rst_out_err", {31'd0, out_err}, 32'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    core_en = 1'b1;
    @(negedge clk);
    check("in_ready_after_mid_rst", {31'd0, in_ready}, 32'd1);
    repeat (10) @(negedge clk);
    check("no_resp_after_rst", {31'd0, out_valid}, 32'd0);
    push(16'd9, 16'd6, 1'b0);
    drain();

    // Spurious done in IDLE.
    done_spur = 1'b1;
    @(negedge clk);
    done_spur = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("spur_no_valid", {31'd0, out_valid}, 32'd0);
      check("spur_no_clr", {31'd0, gcd_clr}, 32'd0);
      @(negedge clk);
    end
    push(16'd15, 16'd10, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks_n, fail_n);
    $finish;
  end

endmodule
